ram_responder: RTL
==================

// Module: ram_responder
// PURPOSE
// - Memory-side responder for the CPU RAM port: answers the fetch/mem-write stage's
//   mem_en/rd_en/wr_en/addr/data requests with word reads and writes.
// - Owns the unified instruction/data word array. Adds a host boot-load port that
//   fills memory before the CPU is released from hold.
// - Sits between the CPU core and the top level; one responder per CPU.
// PARAMETERS
// - ADDR_WIDTH  12  width of the word address from the CPU; array depth = 2**(ADDR_WIDTH-1)
// - DATA_WIDTH  16  word width
// - READ_LAT    1   read latency in cycles; legal range 1..4, which the CPU 4-cycle fetch hold covers
// PORTS
// - clk                 in   1           system clock, rising edge
// - rst                 in   1           asynchronous, active-low reset (rst==0 resets)
// - i_1_mem_en          in   1           CPU request enable
// - i_1_mem_rd_en       in   1           CPU read strobe
// - i_1_mem_wr_en       in   1           CPU write strobe; takes priority over rd_en
// - i_A_addr_cpu2mem    in   ADDR_WIDTH  word address (CPU byte address >> 1)
// - i_16_data_cpu2mem   in   DATA_WIDTH  write data, stored as presented (no byte swap)
// - o_16_data_mem2cpu   out  DATA_WIDTH  read data, registered
// - o_1_rd_valid        out  1           o_16_data_mem2cpu holds a completed read this cycle
// - o_1_addr_err        out  1           sticky: CPU accessed with address MSB set
// - i_1_load_valid      in   1           host load beat valid
// - o_1_load_ready      out  1           responder accepts a load beat
// - i_A_load_addr       in   ADDR_WIDTH  host load word address
// - i_16_load_data      in   DATA_WIDTH  host load word
// - i_1_load_done       in   1           host pulse: boot image complete
// - o_1_cpu_hold        out  1           held high while loading; top ORs it into the CPU reset
// BEHAVIOUR
// - Reset (rst==0, async):
//   - state=LOAD; o_16_data_mem2cpu=0, o_1_rd_valid=0, o_1_addr_err=0
//   - o_1_load_ready=0, o_1_cpu_hold=1; the read pipeline is flushed.
//   - Array contents are not reset.
// - FSM LOAD:
//   - o_1_load_ready=1 from the first clock after reset release.
//   - A beat completes when valid&&ready: array[load_addr[ADDR_WIDTH-2:0]] <= load_data.
//   - All CPU strobes are ignored; data output = 0.
// - LOAD -> RUN: on i_1_load_done==1 at a clock edge.
//   - A beat in that same cycle is still written.
//   - Next cycle: load_ready=0, cpu_hold=0.
// - FSM RUN:
//   - Load port is ignored (ready=0). There is no return to LOAD except by reset.
//   - Write: mem_en && wr_en writes array[addr[ADDR_WIDTH-2:0]] at the edge. No read is issued.
//   - Read: mem_en && rd_en && !wr_en issues a read. The data appears on o_16_data_mem2cpu
//     with o_1_rd_valid=1 exactly READ_LAT cycles after the issuing edge.
//   - Reads are fully pipelined: one issue per cycle, responses in issue order.
//   - Read-after-write: a read issued in the cycle after a write to the same address
//     returns the new data.
//   - Cycles with no read response: o_16_data_mem2cpu=0, rd_valid=0. The CPU relies on
//     zero data outside valid reads.
//   - mem_en==0: no access; in-flight reads still complete.
//   - Address MSB set: the access uses the lower bits (wrap) and sets o_1_addr_err until reset.
// - Reset mid-read:
//   - All in-flight responses are discarded.
//   - Output returns to 0 asynchronously.
// STRUCTURE
// - Shared package holds:
//   - state encoding: LOAD=1'b0, RUN=1'b1
//   - MAX_READ_LAT=4
//   - the default widths shared with the CPU stage
// - Sub-module ram_rd_pipe:
//   - a READ_LAT-deep shift register of {valid, data}
//   - async active-low reset clears the valid bits and data.
// - Top level holds the array, the FSM, the write path and the error flag.
// TESTING
// - Load 0x1234@0 and 0xABCD@5, pulse load_done, then CPU read addr 5
//   -> rd_valid and data 0xABCD exactly READ_LAT cycles later.
// - Back-to-back CPU reads of addr 0,5,0 on consecutive cycles
//   -> 0x1234, 0xABCD, 0x1234 on three consecutive valid cycles.
// - CPU write 0x55AA@7, read @7 next cycle
//   -> 0x55AA; with rd_en and wr_en both high, write only and rd_valid stays 0.
// - Read addr 0x801 -> returns array[1] and o_1_addr_err=1, which stays set
//   through later legal accesses.
// - CPU strobes while in LOAD -> no array change, data 0.
//   load_done together with a valid beat -> that beat is written, then cpu_hold falls.
// - Assert rst=0 mid-cycle while a read is in flight (READ_LAT=3)
//   -> outputs 0 immediately, no valid after release, state LOAD.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared state encoding and default widths for the RAM responder
package ram_responder_pkg;

  // Responder modes: host boot-load first, then CPU service until reset.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_READ_LAT   = 4;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - CPU request/response and host boot-load signals
interface ram_responder_if #(
  parameter int ADDR_WIDTH = ram_responder_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_responder_pkg::DEF_DATA_WIDTH
) ();

  // CPU request side
  logic                  i_1_mem_en;
  logic                  i_1_mem_rd_en;
  logic                  i_1_mem_wr_en;
  logic [ADDR_WIDTH-1:0] i_A_addr_cpu2mem;
  logic [DATA_WIDTH-1:0] i_16_data_cpu2mem;
  // CPU response side
  logic [DATA_WIDTH-1:0] o_16_data_mem2cpu;
  logic                  o_1_rd_valid;
  logic                  o_1_addr_err;
  // host boot-load side
  logic                  i_1_load_valid;
  logic                  o_1_load_ready;
  logic [ADDR_WIDTH-1:0] i_A_load_addr;
  logic [DATA_WIDTH-1:0] i_16_load_data;
  logic                  i_1_load_done;
  logic                  o_1_cpu_hold;

  // CPU stage plus host loader
  modport master (
    output i_1_mem_en, i_1_mem_rd_en, i_1_mem_wr_en, i_A_addr_cpu2mem, i_16_data_cpu2mem,
    output i_1_load_valid, i_A_load_addr, i_16_load_data, i_1_load_done,
    input  o_16_data_mem2cpu, o_1_rd_valid, o_1_addr_err, o_1_load_ready, o_1_cpu_hold
  );

  // memory responder
  modport slave (
    input  i_1_mem_en, i_1_mem_rd_en, i_1_mem_wr_en, i_A_addr_cpu2mem, i_16_data_cpu2mem,
    input  i_1_load_valid, i_A_load_addr, i_16_load_data, i_1_load_done,
    output o_16_data_mem2cpu, o_1_rd_valid, o_1_addr_err, o_1_load_ready, o_1_cpu_hold
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - READ_LAT-deep {valid, data} shift register for read responses
module ram_rd_pipe #(
  parameter int DATA_WIDTH = ram_responder_pkg::DEF_DATA_WIDTH,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [READ_LAT-1:0]   valid_q;
  logic [DATA_WIDTH-1:0] data_q [READ_LAT];

  // Shift responses toward the output; data is forced to zero in empty slots so
  // the CPU sees zero whenever no read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= issue_i;
      data_q[0]  <= issue_i ? data_i : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[READ_LAT-1];
  assign data_o  = data_q[READ_LAT-1];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - unified word RAM with boot-load port and pipelined CPU reads
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  ram_responder_if.slave  bus
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  state_e                state_q;
  logic                  load_ready_q;
  logic                  cpu_hold_q;
  logic                  addr_err_q;

  logic                  in_run;
  logic                  cpu_access;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic                  load_beat;
  logic [IDX_W-1:0]      cpu_idx;
  logic [IDX_W-1:0]      load_idx;
  logic                  unused_load_msb;

  assign in_run     = (state_q == RUN);
  // Write wins over read when both strobes are high.
  assign cpu_access = in_run && bus.i_1_mem_en && (bus.i_1_mem_rd_en || bus.i_1_mem_wr_en);
  assign cpu_wr     = in_run && bus.i_1_mem_en && bus.i_1_mem_wr_en;
  assign cpu_rd     = in_run && bus.i_1_mem_en && bus.i_1_mem_rd_en && !bus.i_1_mem_wr_en;
  assign load_beat  = !in_run && bus.i_1_load_valid && load_ready_q;
  // The address MSB is outside the array; accesses wrap onto the lower bits.
  assign cpu_idx    = bus.i_A_addr_cpu2mem[IDX_W-1:0];
  assign load_idx   = bus.i_A_load_addr[IDX_W-1:0];
  assign unused_load_msb = bus.i_A_load_addr[ADDR_WIDTH-1];

  // Array writes: host beats in LOAD, CPU writes in RUN (never both). No reset on contents.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      mem_q[load_idx] <= bus.i_16_load_data;
    end else if (cpu_wr) begin
      mem_q[cpu_idx] <= bus.i_16_data_cpu2mem;
    end
  end

  // Mode FSM with registered load handshake, CPU hold and sticky address error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD;
      load_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      addr_err_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.i_1_load_done) begin
            state_q      <= RUN;
            load_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
          end else begin
            load_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (cpu_access && bus.i_A_addr_cpu2mem[ADDR_WIDTH-1]) addr_err_q <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // The array is read at the issuing edge, so a write on the previous edge is already visible.
  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .READ_LAT   (READ_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst),
    .issue_i (cpu_rd),
    .data_i  (mem_q[cpu_idx]),
    .valid_o (bus.o_1_rd_valid),
    .data_o  (bus.o_16_data_mem2cpu)
  );

  assign bus.o_1_addr_err   = addr_err_q;
  assign bus.o_1_load_ready = load_ready_q;
  assign bus.o_1_cpu_hold   = cpu_hold_q;

endmodule
